// File: rtl/uart_tx_stim.sv
// UART transmitter with a power-of-two byte FIFO in front; frame format and
// baud divisor are fixed at elaboration.
module uart_tx_stim #(
  parameter int unsigned DIV       = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       overflow,
  output logic                       txd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DIV);
  localparam int unsigned NW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                state;
  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_BITS-1:0]  head;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic [BW-1:0]         baud_cnt;
  logic [NW-1:0]         bit_cnt;
  logic                  push;
  logic                  pop;
  logic                  baud_end;
  logic                  stop_end;
  logic [CW-1:0]         count_nxt;

  // Pop decision is shared by the FIFO bookkeeping and the FSM load.
  always_comb begin
    push      = wr_en && !full;
    baud_end  = (baud_cnt == BW'(DIV - 1));
    stop_end  = baud_end && (bit_cnt == NW'(STOP_BITS - 1));
    pop       = !empty && ((state == IDLE) || ((state == STOP) && stop_end));
    head      = mem[rd_ptr];
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // A write against a full FIFO is dropped even if a pop frees a slot now.
      if (wr_en && full) overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg    <= head;
            par_bit  <= (^head) ^ (PARITY == 1);
            txd      <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == NW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                txd   <= par_bit;
                state <= PAR;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + NW'(1);
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        PAR: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (stop_end) begin
              bit_cnt <= '0;
              // Back-to-back frames: start bit follows the last stop bit directly.
              if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ (PARITY == 1);
                txd     <= 1'b0;
                state   <= START;
              end else begin
                txd   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + NW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
